// File: rtl/rob_retire_pkg.sv
// Shared register/ROB types for the Tomasulo core: architectural and physical
// register indices, the rename mapping pair and the reorder buffer entry layout.
package rob_retire_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int ROB_DEPTH    = 8;
    localparam int TAG_LEN      = $clog2(ROB_DEPTH);

    typedef logic [REG_ADDR_LEN-1:0] arch_reg_t;
    typedef logic [REG_ADDR_LEN-1:0] phys_idx_t;
    typedef logic [TAG_LEN-1:0]      rob_tag_t;
    typedef logic [TAG_LEN:0]        rob_cnt_t;

    typedef struct packed {
        phys_idx_t dest;
        phys_idx_t dest_old;
    } phys_reg_t;

    typedef struct packed {
        logic      valid;
        logic      ready;
        arch_reg_t arch_dest;
        phys_idx_t phys_dest;
        phys_idx_t phys_old;
    } rob_entry_t;

    // Physical register 0 is the x0/reset mapping and must never reach the free list.
    function automatic logic freesPhysReg(input rob_entry_t e);
        return (e.arch_dest != '0) && (e.phys_old != '0);
    endfunction

endpackage

// File: rtl/rob_retire_if.sv
// Dispatch, completion, flush and commit signals between the renamer/CDB side
// (master) and the reorder buffer (slave).
interface rob_retire_if;
    import rob_retire_pkg::*;

    logic      dispatch_valid;
    logic      dispatch_ready;
    arch_reg_t dispatch_arch_dest;
    phys_idx_t dispatch_phys_dest;
    phys_idx_t dispatch_phys_old;
    rob_tag_t  dispatch_tag;
    logic      cdb_valid;
    rob_tag_t  cdb_tag;
    logic      flush;
    logic      commit_flag;
    phys_idx_t commit_phys_reg;
    logic      commit_valid;
    arch_reg_t commit_arch_dest;
    phys_idx_t commit_phys_dest;
    rob_cnt_t  rob_count;
    logic      rob_empty;

    modport master (
        output dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_old,
        output cdb_valid, cdb_tag, flush,
        input  dispatch_ready, dispatch_tag,
        input  commit_flag, commit_phys_reg, commit_valid, commit_arch_dest, commit_phys_dest,
        input  rob_count, rob_empty
    );

    modport slave (
        input  dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_old,
        input  cdb_valid, cdb_tag, flush,
        output dispatch_ready, dispatch_tag,
        output commit_flag, commit_phys_reg, commit_valid, commit_arch_dest, commit_phys_dest,
        output rob_count, rob_empty
    );

endinterface

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates at tail on dispatch, marks entries ready from
// the CDB and retires at most one ready head entry per cycle with registered commit outputs.
module rob_retire
    import rob_retire_pkg::*;
(
    input logic         clk,
    input logic         reset,
    rob_retire_if.slave bus
);

    rob_entry_t entries_q [ROB_DEPTH];
    rob_entry_t entries_d [ROB_DEPTH];
    rob_tag_t   head_q, head_d;
    rob_tag_t   tail_q, tail_d;
    rob_cnt_t   count_q, count_d;

    logic       commitValid_q, commitValid_d;
    logic       commitFlag_q, commitFlag_d;
    phys_idx_t  commitPhysReg_q, commitPhysReg_d;
    arch_reg_t  commitArchDest_q, commitArchDest_d;
    phys_idx_t  commitPhysDest_q, commitPhysDest_d;

    logic       full;
    logic       dispatchFire;
    logic       retireFire;
    rob_entry_t headEntry;

    // Readiness comes from the registered count only, so a same-cycle retire never opens a slot.
    assign full         = (count_q == rob_cnt_t'(ROB_DEPTH));
    assign headEntry    = entries_q[head_q];
    assign dispatchFire = bus.dispatch_valid && !full;
    assign retireFire   = headEntry.valid && headEntry.ready;

    assign bus.dispatch_ready   = !full;
    assign bus.dispatch_tag     = tail_q;
    assign bus.rob_count        = count_q;
    assign bus.rob_empty        = (count_q == '0);
    assign bus.commit_valid     = commitValid_q;
    assign bus.commit_flag      = commitFlag_q;
    assign bus.commit_phys_reg  = commitPhysReg_q;
    assign bus.commit_arch_dest = commitArchDest_q;
    assign bus.commit_phys_dest = commitPhysDest_q;

    always_comb begin
        entries_d        = entries_q;
        head_d           = head_q + rob_tag_t'(retireFire);
        tail_d           = tail_q + rob_tag_t'(dispatchFire);
        count_d          = count_q + rob_cnt_t'(dispatchFire) - rob_cnt_t'(retireFire);
        commitValid_d    = retireFire;
        commitFlag_d     = retireFire && freesPhysReg(headEntry);
        commitPhysReg_d  = (retireFire && freesPhysReg(headEntry)) ? headEntry.phys_old : '0;
        commitArchDest_d = retireFire ? headEntry.arch_dest : '0;
        commitPhysDest_d = retireFire ? headEntry.phys_dest : '0;

        if (bus.cdb_valid && entries_q[bus.cdb_tag].valid) begin
            entries_d[bus.cdb_tag].ready = 1'b1;
        end
        if (retireFire) begin
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].ready = 1'b0;
        end
        // Tail never aliases a live entry here: full blocks dispatch, empty blocks retire.
        if (dispatchFire) begin
            entries_d[tail_q] = '{valid:     1'b1,
                                  ready:     1'b0,
                                  arch_dest: bus.dispatch_arch_dest,
                                  phys_dest: bus.dispatch_phys_dest,
                                  phys_old:  bus.dispatch_phys_old};
        end

        if (bus.flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d           = '0;
            tail_d           = '0;
            count_d          = '0;
            commitValid_d    = 1'b0;
            commitFlag_d     = 1'b0;
            commitPhysReg_d  = '0;
            commitArchDest_d = '0;
            commitPhysDest_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            commitValid_q    <= 1'b0;
            commitFlag_q     <= 1'b0;
            commitPhysReg_q  <= '0;
            commitArchDest_q <= '0;
            commitPhysDest_q <= '0;
        end else begin
            entries_q        <= entries_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            commitValid_q    <= commitValid_d;
            commitFlag_q     <= commitFlag_d;
            commitPhysReg_q  <= commitPhysReg_d;
            commitArchDest_q <= commitArchDest_d;
            commitPhysDest_q <= commitPhysDest_d;
        end
    end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer and retire unit for the Tomasulo core.
- Accepts renamed instructions at dispatch and marks them complete from the CDB.
- Retires them in program order.
- On retire, returns the superseded physical register to the rename free list (commit_flag / commit_phys_reg) and reports the committed arch-to-phys mapping.

Parameters:
- ROB_DEPTH, 8, number of entries; power of two, at least 2.
- TAG_LEN, 3, log2(ROB_DEPTH); ROB tag width.
- REG_ADDR_LEN, 5, physical and architectural register index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high; one clock; sampled on posedge clk.
- dispatch_valid  input  1  new instruction from the renamer.
- dispatch_ready  output  1  equals !full; dispatch accepted only when dispatch_valid && dispatch_ready.
- dispatch_arch_dest  input  REG_ADDR_LEN  architectural destination.
- dispatch_phys_dest  input  REG_ADDR_LEN  newly assigned physical destination (PHYS_REG.dest).
- dispatch_phys_old  input  REG_ADDR_LEN  previous mapping (PHYS_REG.dest_old).
- dispatch_tag  output  TAG_LEN  tail index; tag given to the accepted instruction this cycle.
- cdb_valid  input  1  completion broadcast.
- cdb_tag  input  TAG_LEN  completing ROB entry.
- flush  input  1  discard all in-flight entries.
- commit_flag  output  1  registered one-cycle pulse; free dispatch_phys_old of retired entry.
- commit_phys_reg  output  REG_ADDR_LEN  register returned to free list.
- commit_valid  output  1  registered; an entry retired this cycle.
- commit_arch_dest  output  REG_ADDR_LEN  retired arch destination.
- commit_phys_dest  output  REG_ADDR_LEN  retired phys destination.
- rob_count  output  TAG_LEN+1  occupied entries.
- rob_empty  output  1  rob_count == 0.

Behaviour:
- State:
  - Circular buffer with head (oldest) and tail (next free) pointers of TAG_LEN bits; both wrap modulo ROB_DEPTH.
  - Registered count of 0..ROB_DEPTH.
  - Per entry: valid, ready, arch_dest, phys_dest, phys_old.
- Reset: head = tail = count = 0; all valid/ready bits = 0; commit_flag = commit_valid = 0; commit_phys_reg = commit_arch_dest = commit_phys_dest = 0; dispatch_ready = 1; rob_empty = 1.
- Dispatch:
  - On an accepted dispatch, the entry at tail is written with valid = 1, ready = 0, and tail increments.
  - dispatch_tag is combinational and equals tail.
  - dispatch_ready is derived from registered count only; a commit in the same cycle does not open a slot when full.
- Completion:
  - cdb_valid with a valid entry at cdb_tag sets ready = 1 at the edge.
  - cdb_valid with an invalid entry at cdb_tag is ignored.
  - A duplicate completion is harmless.
- Retire:
  - Evaluated from registered state. If entry[head] is valid and ready, then at the edge:
    - commit_valid <= 1;
    - commit_arch_dest and commit_phys_dest <= the entry's fields;
    - entry[head].valid <= 0;
    - head increments.
  - At most one retire per cycle.
  - Completion-to-retire latency: a CDB at edge E sets ready; retire occurs at edge E+1. Outputs are visible for one cycle after E+1.
  - commit_flag <= 1 only if the retired entry has arch_dest != 0 and phys_old != 0. Physical register 0 is never returned, since it is the x0/reset mapping.
  - commit_phys_reg <= phys_old when commit_flag is set, else 0.
  - When no retire occurs, commit_valid = commit_flag = 0 and the data outputs are 0.
- Simultaneous events:
  - Dispatch and retire in one cycle: count is unchanged.
  - CDB and dispatch in one cycle never target the same slot.
  - Head retire and a CDB to another tag both apply.
- Flush (priority below reset, above everything else): at the edge, head = tail = count = 0, all valid/ready = 0, commit outputs = 0. Any dispatch or CDB in that cycle is dropped.
- Reset mid-operation: identical to the reset state, and no commit pulse is emitted.
- Full: count == ROB_DEPTH, so dispatch_ready = 0. Empty: no retire.

Decomposition:
- Add ROB_DEPTH, TAG_LEN and a ROB_ENTRY packed struct (valid, ready, arch_dest, phys_dest, phys_old) to the shared header that holds ARCH_REG/PHYS_REG and REG_ADDR_LEN.
- No sub-module: the pointer/count logic is too small to split out.

Test Plan:
- Reset, then dispatch {arch 3, phys 1, old 0}, CDB tag 0 -> commit_valid pulses with arch 3, phys 1; commit_flag = 0 (old = 0); rob_empty returns to 1.
- Dispatch tags 0,1,2 with old = 4,5,6; complete in order 2,0,1 -> commits occur in order 0,1,2 on consecutive cycles with commit_phys_reg 4,5,6.
- Dispatch 8 entries -> dispatch_ready = 0 and rob_count = 8; a 9th dispatch_valid is ignored; after one retire, dispatch_ready = 1 and dispatch_tag = 0 (wrap).
- Dispatch arch 0 {phys 0, old 7}, complete -> commit_valid = 1, commit_flag = 0.
- Three entries in flight, one ready; assert flush -> no commit, rob_count = 0, the next dispatch gets tag 0.
- At full with head ready, dispatch_valid held -> retire occurs; dispatch is accepted the following cycle; count goes 8, 7, 8.
